// File: rtl/ecg_result_framer_pkg.sv
// ecg_result_framer_pkg: shared frame constants, sample index type and framer state encoding.
package ecg_result_framer_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int FRAME_LEN = 5;

    typedef logic [21:0] sample_num;

    typedef enum logic [2:0] {IDLE, HDR, B0, B1, B2, CHK} frame_state;

    function automatic logic [7:0] frame_chk(input logic [7:0] hdr, input sample_num s);
        return hdr ^ s[7:0] ^ s[15:8] ^ {2'b00, s[21:16]};
    endfunction

endpackage

// File: rtl/ecg_result_framer.sv
// ecg_result_framer: serializes R-peak sample indices into 5-byte header/payload/XOR frames for the UART.
module ecg_result_framer
    import ecg_result_framer_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE = FRAME_HDR,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  sample_num            in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    frame_state state, state_nx;
    sample_num  data;
    logic [7:0] chk, byte_nx;
    logic       ready, accept, shake;

    // ready is a register so in_ready never depends on tx_ready and stays low the cycle after reset
    assign in_ready = ready && en;
    assign accept   = in_valid && in_ready;
    assign shake    = tx_valid && tx_ready;
    assign busy     = state != IDLE;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? HDR : IDLE;
            HDR:     state_nx = shake ? B0 : HDR;
            B0:      state_nx = shake ? B1 : B0;
            B1:      state_nx = shake ? B2 : B1;
            B2:      state_nx = shake ? CHK : B2;
            CHK:     state_nx = shake ? IDLE : CHK;
            default: state_nx = IDLE;
        endcase
    end

    // byte for the state being entered; the header needs no latched data so IDLE->HDR is safe
    always_comb begin
        byte_nx = 8'h00;
        case (state_nx)
            HDR:     byte_nx = HDR_BYTE;
            B0:      byte_nx = data[7:0];
            B1:      byte_nx = data[15:8];
            B2:      byte_nx = {2'b00, data[21:16]};
            CHK:     byte_nx = chk;
            default: byte_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            ready     <= 1'b0;
            frame_cnt <= '0;
            data      <= '0;
            chk       <= '0;
        end else begin
            tx_data  <= byte_nx;
            tx_valid <= state_nx != IDLE;
            ready    <= state_nx == IDLE;
            if (accept) begin
                data <= in_data;
                chk  <= frame_chk(HDR_BYTE, in_data);
            end
            if (state == CHK && shake) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule
